// File: rtl/neurex_pkg.sv
// Shared definitions for the neurex GEMM scheduler.
//   sched_state_e : scheduler FSM state encoding
//   ceil_div      : rounded-up integer division, also used for tile counts
package neurex_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } sched_state_e;

    // ceil(a/b); a zero divisor yields zero rather than X
    function automatic logic [31:0] ceil_div(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] num;
        logic [32:0] quo;
        if (b == 32'd0) begin
            ceil_div = 32'd0;
        end else begin
            num      = 33'(a) + 33'(b) - 33'd1;
            quo      = num / 33'(b);
            ceil_div = quo[31:0];
        end
    endfunction

endpackage

// File: rtl/neurex_gemm_sched_if.sv
// Job/array handshake bundle between a GEMM job source and the tile scheduler.
//   master : job source and array side (drives start, sizes, arr_ready, flush_ack)
//   slave  : scheduler (drives busy/done/err, read strobes/addresses, enables, flush)
interface neurex_gemm_sched_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned TILE_WIDTH = 5
);
    logic                  start;
    logic [DATA_WIDTH-1:0] num_in;
    logic [DATA_WIDTH-1:0] num_common;
    logic [DATA_WIDTH-1:0] num_out;
    logic                  arr_ready;
    logic                  flush_ack;

    logic                  busy;
    logic                  done;
    logic                  err;
    logic                  in_rd_en;
    logic                  w_rd_en;
    logic [ADDR_WIDTH-1:0] in_rd_addr;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic                  in_en;
    logic                  w_en;
    logic                  acc_flush;
    logic [TILE_WIDTH-1:0] acc_tile;

    modport master (
        output start, num_in, num_common, num_out, arr_ready, flush_ack,
        input  busy, done, err, in_rd_en, w_rd_en, in_rd_addr, w_rd_addr,
               in_en, w_en, acc_flush, acc_tile
    );

    modport slave (
        input  start, num_in, num_common, num_out, arr_ready, flush_ack,
        output busy, done, err, in_rd_en, w_rd_en, in_rd_addr, w_rd_addr,
               in_en, w_en, acc_flush, acc_tile
    );
endinterface

// File: rtl/neurex_tile_cnt.sv
// Nested tile counter: ct is the inner index, rt the outer one.
//   i_clr     : restart at tile 0 (job accept)
//   i_adv     : step to the next tile
//   i_rt_tot  : number of row tiles, i_ct_tot : number of column tiles
//   o_rt/o_ct : current tile coordinates
//   o_last    : current tile is the final one of the job
//   o_tile    : running tile id modulo ACCUM_SIZE
module neurex_tile_cnt #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ACCUM_SIZE = 32
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          i_clr,
    input  logic                          i_adv,
    input  logic [DATA_WIDTH-1:0]         i_rt_tot,
    input  logic [DATA_WIDTH-1:0]         i_ct_tot,
    output logic [DATA_WIDTH-1:0]         o_rt,
    output logic [DATA_WIDTH-1:0]         o_ct,
    output logic                          o_last,
    output logic [$clog2(ACCUM_SIZE)-1:0] o_tile
);
    localparam int unsigned DW     = DATA_WIDTH;
    localparam int unsigned TILE_W = $clog2(ACCUM_SIZE);

    logic [DW-1:0]     r_rt;
    logic [DW-1:0]     r_ct;
    logic [TILE_W-1:0] r_tile;
    logic              w_ct_last;
    logic              w_rt_last;

    assign w_ct_last = (r_ct == i_ct_tot - DW'(1));
    assign w_rt_last = (r_rt == i_rt_tot - DW'(1));

    // Tile id is tracked incrementally so no rt*CT multiply is needed
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rt   <= '0;
            r_ct   <= '0;
            r_tile <= '0;
        end else if (i_clr) begin
            r_rt   <= '0;
            r_ct   <= '0;
            r_tile <= '0;
        end else if (i_adv) begin
            if (w_ct_last) begin
                r_ct <= '0;
                r_rt <= r_rt + DW'(1);
            end else begin
                r_ct <= r_ct + DW'(1);
            end
            r_tile <= (r_tile == TILE_W'(ACCUM_SIZE - 1)) ? '0 : r_tile + TILE_W'(1);
        end
    end

    assign o_rt   = r_rt;
    assign o_ct   = r_ct;
    assign o_last = w_ct_last && w_rt_last;
    assign o_tile = r_tile;
endmodule

// File: rtl/neurex_gemm_sched.sv
// GEMM tile scheduler: splits an (num_in x num_common)*(num_common x num_out)
// job into SYS_ROW x SYS_COL output tiles and sequences buffer reads, array
// enables and accumulator flushes for each tile.
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : job interface (start/sizes/busy/done/err), buffer read
//               strobes and addresses, array enables, accumulator flush
module neurex_gemm_sched #(
    parameter int unsigned SYS_ROW    = 4,
    parameter int unsigned SYS_COL    = 4,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned ACCUM_SIZE = 32
) (
    input  logic                clk,
    input  logic                rstn,
    neurex_gemm_sched_if.slave  bus
);
    import neurex_pkg::*;

    localparam int unsigned DW        = DATA_WIDTH;
    localparam int unsigned PROD_W    = 2 * DATA_WIDTH;
    localparam int unsigned TILE_W    = $clog2(ACCUM_SIZE);
    localparam int unsigned DRAIN_LEN = SYS_ROW + SYS_COL - 1;
    localparam int unsigned DCNT_W    = $clog2(DRAIN_LEN + 1);

    localparam logic [2:0] S_IDLE  = 3'(ST_IDLE);
    localparam logic [2:0] S_LOAD  = 3'(ST_LOAD);
    localparam logic [2:0] S_DRAIN = 3'(ST_DRAIN);
    localparam logic [2:0] S_FLUSH = 3'(ST_FLUSH);
    localparam logic [2:0] S_DONE  = 3'(ST_DONE);

    logic [2:0]        r_state;
    logic [DW-1:0]     r_k;
    logic [DCNT_W-1:0] r_dcnt;
    logic [DW-1:0]     r_nc;
    logic [DW-1:0]     r_rt_tot;
    logic [DW-1:0]     r_ct_tot;
    logic              r_err;
    logic              r_in_en;
    logic              r_w_en;

    logic [2:0]        w_state_nxt;
    logic [DW-1:0]     w_k_nxt;
    logic [DCNT_W-1:0] w_dcnt_nxt;
    logic              w_accept;
    logic              w_rd_en;
    logic              w_clr;
    logic              w_adv;
    logic              w_zero;
    logic [DW-1:0]     w_rt;
    logic [DW-1:0]     w_ct;
    logic              w_last;
    logic [TILE_W-1:0] w_tile;
    logic [PROD_W-1:0] w_in_prod;
    logic [PROD_W-1:0] w_w_prod;

    assign w_zero = (bus.num_in == '0) || (bus.num_common == '0) || (bus.num_out == '0);

    neurex_tile_cnt #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACCUM_SIZE (ACCUM_SIZE)
    ) u_tile_cnt (
        .clk      (clk),
        .rstn     (rstn),
        .i_clr    (w_clr),
        .i_adv    (w_adv),
        .i_rt_tot (r_rt_tot),
        .i_ct_tot (r_ct_tot),
        .o_rt     (w_rt),
        .o_ct     (w_ct),
        .o_last   (w_last),
        .o_tile   (w_tile)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= S_IDLE;
            r_k      <= '0;
            r_dcnt   <= '0;
            r_nc     <= '0;
            r_rt_tot <= '0;
            r_ct_tot <= '0;
            r_err    <= 1'b0;
            r_in_en  <= 1'b0;
            r_w_en   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
            r_dcnt  <= w_dcnt_nxt;
            r_in_en <= w_rd_en;
            r_w_en  <= w_rd_en;
            if (w_accept) begin
                r_nc     <= bus.num_common;
                r_rt_tot <= DW'(ceil_div(32'(bus.num_in), 32'(SYS_ROW)));
                r_ct_tot <= DW'(ceil_div(32'(bus.num_out), 32'(SYS_COL)));
                r_err    <= w_zero;
            end
        end
    end

    // Next-state logic; read strobes follow arr_ready within the same cycle
    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_dcnt_nxt  = r_dcnt;
        w_accept    = 1'b0;
        w_rd_en     = 1'b0;
        w_clr       = 1'b0;
        w_adv       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_clr       = 1'b1;
                    w_k_nxt     = '0;
                    w_state_nxt = w_zero ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (bus.arr_ready) begin
                    w_rd_en = 1'b1;
                    if (r_k == r_nc - DW'(1)) begin
                        w_k_nxt     = '0;
                        w_dcnt_nxt  = '0;
                        w_state_nxt = S_DRAIN;
                    end else begin
                        w_k_nxt = r_k + DW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (r_dcnt == DCNT_W'(DRAIN_LEN - 1)) begin
                    w_state_nxt = S_FLUSH;
                end else begin
                    w_dcnt_nxt = r_dcnt + DCNT_W'(1);
                end
            end
            S_FLUSH: begin
                if (bus.flush_ack) begin
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_adv       = 1'b1;
                        w_k_nxt     = '0;
                        w_state_nxt = S_LOAD;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Addresses formed at double width, then truncated to the buffer width
    assign w_in_prod = PROD_W'(w_rt) * PROD_W'(r_nc) + PROD_W'(r_k);
    assign w_w_prod  = PROD_W'(w_ct) * PROD_W'(r_nc) + PROD_W'(r_k);

    assign bus.busy       = (r_state != S_IDLE);
    assign bus.done       = (r_state == S_DONE);
    assign bus.err        = (r_state == S_DONE) && r_err;
    assign bus.in_rd_en   = w_rd_en;
    assign bus.w_rd_en    = w_rd_en;
    assign bus.in_rd_addr = ADDR_WIDTH'(w_in_prod);
    assign bus.w_rd_addr  = ADDR_WIDTH'(w_w_prod);
    assign bus.in_en      = r_in_en;
    assign bus.w_en       = r_w_en;
    assign bus.acc_flush  = (r_state == S_FLUSH);
    assign bus.acc_tile   = w_tile;
endmodule

// File: tb/tb_neurex_gemm_sched.sv
// Directed bench for neurex_gemm_sched (4x4 array, 16-bit sizes/addresses, 32 accumulators).
module tb_neurex_gemm_sched;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    neurex_gemm_sched_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .TILE_WIDTH(5)) bus ();

    neurex_gemm_sched #(
        .SYS_ROW    (4),
        .SYS_COL    (4),
        .DATA_WIDTH (16),
        .ADDR_WIDTH (16),
        .ACCUM_SIZE (32)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a job for one cycle; returns at the drive point of the first LOAD cycle
    task automatic launch(input int ni, input int nc, input int no);
        @(posedge clk); #1;
        bus.num_in     = 16'(ni);
        bus.num_common = 16'(nc);
        bus.num_out    = 16'(no);
        bus.start      = 1'b1;
        @(posedge clk); #1;
        bus.start      = 1'b0;
    endtask

    int   t, j, busy_cnt, flush_cnt;
    logic exp_rd, exp_en, exp_fl;

    initial begin
        rstn           = 1'b0;
        bus.start      = 1'b0;
        bus.num_in     = '0;
        bus.num_common = '0;
        bus.num_out    = '0;
        bus.arr_ready  = 1'b1;
        bus.flush_ack  = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        chk("rst_busy",  32'(bus.busy),       32'd0);
        chk("rst_done",  32'(bus.done),       32'd0);
        chk("rst_err",   32'(bus.err),        32'd0);
        chk("rst_rd",    32'(bus.in_rd_en),   32'd0);
        chk("rst_wrd",   32'(bus.w_rd_en),    32'd0);
        chk("rst_en",    32'(bus.in_en),      32'd0);
        chk("rst_flush", 32'(bus.acc_flush),  32'd0);
        chk("rst_tile",  32'(bus.acc_tile),   32'd0);
        chk("rst_iaddr", 32'(bus.in_rd_addr), 32'd0);
        chk("rst_waddr", 32'(bus.w_rd_addr),  32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;

        // 8x8 * 8x16: 2 row tiles x 4 col tiles, 16 cycles each
        launch(8, 8, 16);
        busy_cnt = 0;
        for (int i = 0; i < 130; i++) begin
            t      = i / 16;
            j      = i % 16;
            exp_rd = (i < 128) && (j < 8);
            exp_en = (i >= 1) && (i <= 128) && (((i - 1) % 16) < 8);
            exp_fl = (i < 128) && (j == 15);
            #1;
            chk("t1_rd",  32'(bus.in_rd_en),  32'(exp_rd));
            chk("t1_wrd", 32'(bus.w_rd_en),   32'(exp_rd));
            chk("t1_en",  32'(bus.in_en),     32'(exp_en));
            chk("t1_wen", 32'(bus.w_en),      32'(exp_en));
            if (exp_rd) begin
                chk("t1_iaddr", 32'(bus.in_rd_addr), 32'((t / 4) * 8 + j));
                chk("t1_waddr", 32'(bus.w_rd_addr),  32'((t % 4) * 8 + j));
            end
            chk("t1_flush", 32'(bus.acc_flush), 32'(exp_fl));
            if (exp_fl) chk("t1_tile", 32'(bus.acc_tile), 32'(t));
            chk("t1_done", 32'(bus.done), 32'(i == 128));
            chk("t1_busy", 32'(bus.busy), 32'(i <= 128));
            chk("t1_err",  32'(bus.err),  32'd0);
            if (bus.busy && !bus.done) busy_cnt++;
            @(posedge clk); #1;
        end
        chk("t1_busy_cycles", 32'(busy_cnt), 32'd128);

        // Zero-size job: done/err on the first cycle, no strobes
        launch(4, 0, 4);
        #1;
        chk("t3_done", 32'(bus.done),     32'd1);
        chk("t3_err",  32'(bus.err),      32'd1);
        chk("t3_busy", 32'(bus.busy),     32'd1);
        chk("t3_rd",   32'(bus.in_rd_en), 32'd0);
        @(posedge clk); #2;
        chk("t3_done2", 32'(bus.done),  32'd0);
        chk("t3_err2",  32'(bus.err),   32'd0);
        chk("t3_busy2", 32'(bus.busy),  32'd0);
        chk("t3_en2",   32'(bus.in_en), 32'd0);
        @(posedge clk); #1;

        // arr_ready low for cycles 2..4 of a single 4x4x4 tile
        launch(4, 4, 4);
        for (int i = 0; i < 17; i++) begin
            bus.arr_ready = !(i >= 2 && i <= 4);
            exp_rd = (i == 0) || (i == 1) || (i == 5) || (i == 6);
            exp_en = (i == 1) || (i == 2) || (i == 6) || (i == 7);
            #1;
            chk("t4_rd", 32'(bus.in_rd_en), 32'(exp_rd));
            chk("t4_en", 32'(bus.in_en),    32'(exp_en));
            if (i <= 6) begin
                chk("t4_iaddr", 32'(bus.in_rd_addr),
                    32'((i <= 1) ? i : ((i <= 5) ? 2 : 3)));
                chk("t4_waddr", 32'(bus.w_rd_addr),
                    32'((i <= 1) ? i : ((i <= 5) ? 2 : 3)));
            end
            chk("t4_flush", 32'(bus.acc_flush), 32'(i == 14));
            chk("t4_done",  32'(bus.done),      32'(i == 15));
            @(posedge clk); #1;
        end
        bus.arr_ready = 1'b1;

        // flush_ack held off for 5 cycles on tile 0 of a two-tile job
        launch(4, 4, 8);
        flush_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            bus.flush_ack = !(i >= 11 && i <= 15);
            exp_rd = (i <= 3) || (i >= 17 && i <= 20);
            exp_fl = (i >= 11 && i <= 16) || (i == 28);
            #1;
            chk("t5_rd",    32'(bus.in_rd_en),  32'(exp_rd));
            chk("t5_flush", 32'(bus.acc_flush), 32'(exp_fl));
            if (exp_fl) chk("t5_tile", 32'(bus.acc_tile), 32'((i == 28) ? 1 : 0));
            if (i >= 17 && i <= 20) begin
                chk("t5_iaddr", 32'(bus.in_rd_addr), 32'(i - 17));
                chk("t5_waddr", 32'(bus.w_rd_addr),  32'(4 + i - 17));
            end
            chk("t5_done", 32'(bus.done), 32'(i == 29));
            if (i <= 16 && bus.acc_flush) flush_cnt++;
            @(posedge clk); #1;
        end
        chk("t5_flush_len", 32'(flush_cnt), 32'd6);
        bus.flush_ack = 1'b1;

        // Reset pulsed during DRAIN of tile 5, then a clean job with a stray start
        launch(8, 8, 16);
        repeat (90) @(posedge clk);
        #2;
        chk("t6_pre_busy",  32'(bus.busy),       32'd1);
        chk("t6_pre_tile",  32'(bus.acc_tile),   32'd5);
        chk("t6_pre_iaddr", 32'(bus.in_rd_addr), 32'd8);
        rstn = 1'b0;
        #1;
        chk("t6_rst_busy",  32'(bus.busy),       32'd0);
        chk("t6_rst_tile",  32'(bus.acc_tile),   32'd0);
        chk("t6_rst_iaddr", 32'(bus.in_rd_addr), 32'd0);
        chk("t6_rst_waddr", 32'(bus.w_rd_addr),  32'd0);
        chk("t6_rst_done",  32'(bus.done),       32'd0);
        chk("t6_rst_flush", 32'(bus.acc_flush),  32'd0);
        repeat (3) begin
            @(posedge clk); #2;
            chk("t6_hold_busy", 32'(bus.busy), 32'd0);
            chk("t6_hold_done", 32'(bus.done), 32'd0);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        launch(4, 4, 4);
        for (int i = 0; i < 16; i++) begin
            bus.start = (i == 3);
            #1;
            chk("t6_rd",   32'(bus.in_rd_en), 32'(i <= 3));
            chk("t6_done", 32'(bus.done),     32'(i == 12));
            chk("t6_busy", 32'(bus.busy),     32'(i <= 12));
            chk("t6_err",  32'(bus.err),      32'd0);
            @(posedge clk); #1;
        end
        bus.start = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
